// File: rtl/rf2mem_pkg.sv
// Shared depth constants and instruction ROM contents for the rf2mem slice.
package rf2mem_pkg;
    localparam int IMEM_WORDS = 32;
    localparam int DMEM_WORDS = 4096;
    localparam int RF_REGS    = 32;

    localparam int IMEM_AW = $clog2(IMEM_WORDS);
    localparam int DMEM_AW = $clog2(DMEM_WORDS);
    localparam int RF_AW   = $clog2(RF_REGS);

    localparam logic [31:0] IMEM_W0 = 32'hFFFF_0023;
    localparam logic [31:0] IMEM_W1 = 32'hFFFF_0103;
    localparam logic [31:0] IMEM_W2 = 32'hFFFF_1023;
    localparam logic [31:0] IMEM_W3 = 32'hFFFF_1103;
endpackage

// File: rtl/bram_dmem.sv
// Byte-writable data RAM with a registered read port; contents survive reset.
module bram_dmem
    import rf2mem_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         we,
    input  logic               write_only,
    input  logic [DMEM_AW-1:0] daddr,
    input  logic [31:0]        datain,
    output logic [31:0]        outdata
);
    logic [31:0] mem [DMEM_WORDS] = '{default: '0};
    logic [31:0] outdata_q, outdata_d;

    // Array is deliberately outside the reset domain; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && write_only) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) mem[daddr][8*b +: 8] <= datain[8*b +: 8];
            end
        end
    end

    always_comb begin
        outdata_d = outdata_q;
        if (!write_only) outdata_d = mem[daddr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) outdata_q <= '0;
        else       outdata_q <= outdata_d;
    end

    assign outdata = outdata_q;
endmodule

// File: rtl/bram_imem.sv
// Instruction ROM: purely combinational lookup, no clock or reset.
module bram_imem
    import rf2mem_pkg::*;
(
    input  logic [IMEM_AW-1:0] addr,
    output logic [31:0]        data
);
    always_comb begin
        data = '0;
        case (addr)
            5'd0:    data = IMEM_W0;
            5'd1:    data = IMEM_W1;
            5'd2:    data = IMEM_W2;
            5'd3:    data = IMEM_W3;
            default: data = '0;
        endcase
    end
endmodule

// File: rtl/rf_bram.sv
// 32x32 register file with hardwired-zero x0 and a registered read port.
module rf_bram
    import rf2mem_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             we_rf,
    input  logic             enable_rf,
    input  logic [RF_AW-1:0] rs1,
    input  logic [RF_AW-1:0] rd,
    input  logic [31:0]      indata,
    output logic [31:0]      rv1
);
    logic [RF_REGS-1:0][31:0] regs_q, regs_d;
    logic [31:0]              rv1_q, rv1_d;

    // x0 is cleared by reset and never written, so it always reads zero.
    always_comb begin
        regs_d = regs_q;
        rv1_d  = rv1_q;
        if (enable_rf) begin
            if (we_rf) begin
                if (rd != '0) regs_d[rd] = indata;
            end else begin
                rv1_d = regs_q[rs1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '0;
            rv1_q  <= '0;
        end else begin
            regs_q <= regs_d;
            rv1_q  <= rv1_d;
        end
    end

    assign rv1 = rv1_q;
endmodule

// File: rtl/rf2mem.sv
// Top: register file, instruction ROM and data RAM side by side, no coupling.
module rf2mem
    import rf2mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we_rf,
    input  logic        enable_rf,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rd,
    input  logic [31:0] indata,
    output logic [31:0] rv1,
    input  logic [31:0] iaddr,
    output logic [31:0] idata,
    input  logic [3:0]  we,
    input  logic        write_only,
    input  logic [11:0] daddr,
    input  logic [31:0] datain,
    output logic [31:0] outdata
);
    // iaddr is a word index; only the low bits select within the 32-word ROM.
    logic unused_iaddr;
    assign unused_iaddr = ^iaddr[31:IMEM_AW];

    rf_bram u_rf (
        .clk       (clk),
        .reset     (reset),
        .we_rf     (we_rf),
        .enable_rf (enable_rf),
        .rs1       (rs1),
        .rd        (rd),
        .indata    (indata),
        .rv1       (rv1)
    );

    bram_imem u_imem (
        .addr (iaddr[IMEM_AW-1:0]),
        .data (idata)
    );

    bram_dmem u_dmem (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .write_only (write_only),
        .daddr      (daddr),
        .datain     (datain),
        .outdata    (outdata)
    );
endmodule

// File: tb/tb_rf2mem.sv
// Scoreboarded bench for rf2mem: driver pushes per-edge expectations, monitor checks them.
module tb_rf2mem;
    logic        clk = 0;
    logic        reset;
    logic        we_rf, enable_rf;
    logic [4:0]  rs1, rd;
    logic [31:0] indata, rv1, iaddr, idata, datain, outdata;
    logic [3:0]  we;
    logic        write_only;
    logic [11:0] daddr;

    rf2mem dut (
        .clk(clk), .reset(reset), .we_rf(we_rf), .enable_rf(enable_rf),
        .rs1(rs1), .rd(rd), .indata(indata), .rv1(rv1),
        .iaddr(iaddr), .idata(idata),
        .we(we), .write_only(write_only), .daddr(daddr), .datain(datain),
        .outdata(outdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] rv1;
        logic [31:0] outd;
        string       nm;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    // Reference model state
    logic [31:0] rf_m [32];
    logic [31:0] dm_m [4096];
    logic [31:0] rv1_m, out_m;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] rom_word(int i);
        case (i)
            0: return 32'hFFFF0023;
            1: return 32'hFFFF0103;
            2: return 32'hFFFF1023;
            3: return 32'hFFFF1103;
            default: return 32'h0;
        endcase
    endfunction

    // Monitor: after every edge, settle and check all expectations due by now.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #3;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                chk({e.nm, ".rv1"}, rv1, e.rv1);
                chk({e.nm, ".outdata"}, outdata, e.outd);
            end
        end
    end

    // One clocked transaction; the model decides what the coming edge should produce.
    task automatic op(input string nm, input logic rst, input logic wrf, input logic en,
                      input logic [4:0] rs, input logic [4:0] rdi, input logic [31:0] ind,
                      input logic [3:0] w, input logic wo, input logic [11:0] da,
                      input logic [31:0] di);
        exp_t e;
        logic [31:0] mask;
        reset = rst; we_rf = wrf; enable_rf = en; rs1 = rs; rd = rdi; indata = ind;
        we = w; write_only = wo; daddr = da; datain = di;
        if (rst) begin
            foreach (rf_m[i]) rf_m[i] = '0;
            rv1_m = '0;
            out_m = '0;
        end else begin
            if (en) begin
                if (wrf) begin
                    if (rdi != 0) rf_m[rdi] = ind;
                end else begin
                    rv1_m = rf_m[rs];
                end
            end
            if (wo) begin
                mask = '0;
                for (int b = 0; b < 4; b++) if (w[b]) mask[8*b +: 8] = 8'hFF;
                dm_m[da] = (dm_m[da] & ~mask) | (di & mask);
            end else begin
                out_m = dm_m[da];
            end
        end
        e.due = cyc + 1; e.rv1 = rv1_m; e.outd = out_m; e.nm = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic rf_wr(input logic [4:0] r, input logic [31:0] d);
        op("rf_wr", 0, 1, 1, 5'd0, r, d, 4'h0, 1, 12'd0, 32'h0);
    endtask
    task automatic rf_rd(input logic [4:0] r);
        op("rf_rd", 0, 0, 1, r, 5'd0, 32'h0, 4'h0, 1, 12'd0, 32'h0);
    endtask
    task automatic dm_wr(input logic [3:0] w, input logic [11:0] a, input logic [31:0] d);
        op("dm_wr", 0, 0, 0, 5'd0, 5'd0, 32'h0, w, 1, a, d);
    endtask
    task automatic dm_rd(input logic [11:0] a);
        op("dm_rd", 0, 0, 0, 5'd0, 5'd0, 32'h0, 4'hF, 0, a, 32'hFFFF_FFFF);
    endtask

    initial begin
        logic [31:0] a;
        foreach (rf_m[i]) rf_m[i] = '0;
        foreach (dm_m[i]) dm_m[i] = '0;
        rv1_m = '0; out_m = '0;
        reset = 1; we_rf = 0; enable_rf = 0; rs1 = 0; rd = 0; indata = 0;
        iaddr = 0; we = 0; write_only = 1; daddr = 0; datain = 0;
        #1;
        chk("reset_rv1", rv1, 32'h0);
        chk("reset_outdata", outdata, 32'h0);

        // ROM is combinational and indexed by the low five bits only.
        for (int i = 0; i < 32; i++) begin
            a = $urandom();
            a[4:0] = i[4:0];
            iaddr = a;
            #1;
            chk($sformatf("imem[%0d]", i), idata, rom_word(i));
        end

        @(posedge clk); #1;
        // Writes coincident with reset must be discarded.
        op("wr_in_reset", 1, 1, 1, 5'd0, 5'd7, 32'hDEAD_BEEF, 4'hF, 1, 12'd5, 32'hDEAD_BEEF);
        reset = 0;
        rf_rd(5'd7);
        dm_rd(12'd5);

        dm_wr(4'b1111, 12'd0, 32'h1F0F_0F0F);
        dm_rd(12'd0);
        dm_wr(4'b1010, 12'd1, 32'h1111_1111);
        dm_rd(12'd1);
        dm_wr(4'b1000, 12'd2, 32'h3F0F_0F0F);
        dm_rd(12'd2);
        dm_wr(4'b0001, 12'd3, 32'h3F0F_0F0F);
        dm_rd(12'd3);

        rf_wr(5'd10, 32'hFFFF_0000);
        rf_wr(5'd13, 32'h0000_FFFF);
        rf_rd(5'd10);
        rf_rd(5'd13);
        rf_wr(5'd0, 32'hFFFF_FFFF);
        rf_rd(5'd0);
        op("rf_idle", 0, 0, 0, 5'd10, 5'd10, 32'h1234_5678, 4'h0, 1, 12'd0, 32'h0);

        for (int i = 0; i < 300; i++) begin
            op("rand", 0, 1'($urandom()), 1'($urandom()), 5'($urandom()), 5'($urandom()),
               $urandom(), 4'($urandom()), 1'($urandom()), 12'($urandom_range(0, 15)),
               $urandom());
        end

        rf_wr(5'd10, 32'hA5A5_0001);
        rf_rd(5'd10);
        dm_rd(12'd0);

        // Mid-operation reset: outputs must clear without waiting for an edge.
        #3;
        reset = 1;
        #1;
        chk("async_rst_rv1", rv1, 32'h0);
        chk("async_rst_outdata", outdata, 32'h0);
        foreach (rf_m[i]) rf_m[i] = '0;
        rv1_m = '0; out_m = '0;
        @(posedge clk); #1;
        op("wr_in_reset2", 1, 1, 1, 5'd0, 5'd10, 32'h7777_7777, 4'hF, 1, 12'd0, 32'h0);
        reset = 0;
        rf_rd(5'd10);
        rf_rd(5'd13);
        dm_rd(12'd0);
        dm_rd(12'd1);

        repeat (3) @(posedge clk);
        #4;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
